// File: rtl/rtlola_eval_scheduler.sv
// rtlola_eval_scheduler - sequences one RTLola evaluation pipeline, merging queued
// events with periodic deadlines into fixed-length evaluations.
module rtlola_eval_scheduler #(
  parameter int PERIOD_CYCLES = 250,
  parameter int STAGES        = 2,
  parameter int TIMER_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               q_not_empty,
  output logic               q_pop,
  output logic               en_event,
  output logic               en_periodic,
  output logic               slide,
  output logic [1:0]         stage,
  output logic [TIMER_W-1:0] timer,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic {IDLE, EVAL} state_t;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PERIOD_CYCLES - 1);
  localparam logic [1:0]         STAGE_LAST = 2'(STAGES);

  state_t     state, state_d;
  logic [1:0] stage_d;
  logic       pending;
  logic       tick, start;
  logic       q_pop_d, en_event_d, en_periodic_d, slide_d, busy_d;

  assign tick  = en && (timer == TIMER_LAST);
  // A new evaluation may begin when idle or in the final stage cycle (back-to-back).
  assign start = en && (q_not_empty || pending || tick) &&
                 ((state == IDLE) || (stage == STAGE_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      stage       <= '0;
      timer       <= '0;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      q_pop       <= 1'b0;
      en_event    <= 1'b0;
      en_periodic <= 1'b0;
      slide       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      stage       <= stage_d;
      q_pop       <= q_pop_d;
      en_event    <= en_event_d;
      en_periodic <= en_periodic_d;
      slide       <= slide_d;
      busy        <= busy_d;
      if (en) begin
        timer   <= tick ? '0 : timer + 1'b1;
        pending <= start ? 1'b0 : (pending | tick);
      end
      // A deadline is lost only if one is already waiting and no eval absorbs it now.
      if (tick && pending && !start) begin
        overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    stage_d = stage;
    if (en) begin
      if (start) begin
        state_d = EVAL;
        stage_d = 2'd1;
      end else if (state == EVAL) begin
        if (stage == STAGE_LAST) begin
          state_d = IDLE;
          stage_d = 2'd0;
        end else begin
          stage_d = stage + 2'd1;
        end
      end
    end
  end

  always_comb begin
    q_pop_d       = 1'b0;
    slide_d       = 1'b0;
    en_event_d    = en_event;
    en_periodic_d = en_periodic;
    busy_d        = (stage_d != 2'd0);
    if (en) begin
      if (start) begin
        q_pop_d       = q_not_empty;
        en_event_d    = q_not_empty;
        en_periodic_d = pending | tick;
        slide_d       = pending | tick;
      end else if (state_d == IDLE) begin
        en_event_d    = 1'b0;
        en_periodic_d = 1'b0;
      end
    end
  end

endmodule
